// File: rtl/fft16_out_unloader.sv
// Reader end of the 16-point FFT result bus: snapshot on start, rescale/saturate, stream over valid/ready.
// Optional build macro DIGIT_REVERSE_EN presents slot {k[1:0],k[3:2]} at index k (natural frequency order).
module fft16_out_unloader #(
  parameter int N     = 16,
  parameter int OUTW  = 48,
  parameter int DOUTW = 32,
  parameter int SHIFT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N*OUTW-1:0]       yr_flat,
  input  logic [N*OUTW-1:0]       yi_flat,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              out_idx,
  output logic signed [DOUTW-1:0] out_re,
  output logic signed [DOUTW-1:0] out_im,
  output logic                    out_last,
  output logic                    sat_flag,
  output logic                    done
);

  localparam int IW = 4;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic signed [OUTW-1:0] SMAX = {{(OUTW-DOUTW+1){1'b0}}, {(DOUTW-1){1'b1}}};
  localparam logic signed [OUTW-1:0] SMIN = {{(OUTW-DOUTW+1){1'b1}}, {(DOUTW-1){1'b0}}};
  localparam logic [DOUTW-1:0] DMAX = {1'b0, {(DOUTW-1){1'b1}}};
  localparam logic [DOUTW-1:0] DMIN = {1'b1, {(DOUTW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, STREAM, FIN} state_t;

  state_t                 state;
  logic signed [OUTW-1:0] snap_re_p0 [N];
  logic signed [OUTW-1:0] snap_im_p0 [N];
  logic [IW-1:0]          idx_nxt;
  logic [IW-1:0]          slot_nxt;
  logic [DOUTW:0]         sc0_re, sc0_im, scn_re, scn_im;

  // Returns {saturated, value}.
  function automatic logic [DOUTW:0] rescale(input logic signed [OUTW-1:0] s);
    logic signed [OUTW-1:0] t;
    t = s >>> SHIFT;
    if (t > SMAX)      return {1'b1, DMAX};
    else if (t < SMIN) return {1'b1, DMIN};
    else               return {1'b0, t[DOUTW-1:0]};
  endfunction

  function automatic logic [IW-1:0] slot_of(input logic [IW-1:0] k);
`ifdef DIGIT_REVERSE_EN
    return {k[1:0], k[3:2]};
`else
    return k;
`endif
  endfunction

  // Sample 0 comes straight off the input bus (slot 0 in both orders), later ones from the snapshot.
  always_comb begin
    idx_nxt  = out_idx + IW'(1);
    slot_nxt = slot_of(idx_nxt);
    sc0_re   = rescale(yr_flat[OUTW-1:0]);
    sc0_im   = rescale(yi_flat[OUTW-1:0]);
    scn_re   = rescale(snap_re_p0[slot_nxt]);
    scn_im   = rescale(snap_im_p0[slot_nxt]);
  end

  // Stage p0: frame snapshot, data only
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int i = 0; i < N; i++) begin
        snap_re_p0[i] <= yr_flat[i*OUTW +: OUTW];
        snap_im_p0[i] <= yi_flat[i*OUTW +: OUTW];
      end
    end
  end

  // Output stage: control FSM with registered sample presentation
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_re    <= '0;
      out_im    <= '0;
      out_last  <= 1'b0;
      sat_flag  <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= STREAM;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_re    <= sc0_re[DOUTW-1:0];
            out_im    <= sc0_im[DOUTW-1:0];
            out_last  <= 1'b0;
            sat_flag  <= sc0_re[DOUTW] | sc0_im[DOUTW];
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (out_idx == LAST_IDX) begin
              state     <= FIN;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_idx  <= idx_nxt;
              out_re   <= scn_re[DOUTW-1:0];
              out_im   <= scn_im[DOUTW-1:0];
              out_last <= (idx_nxt == LAST_IDX);
              sat_flag <= sat_flag | scn_re[DOUTW] | scn_im[DOUTW];
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fft16_out_unloader.md
Name: fft16_out_unloader

Overview:
- Reader end of the 16-point radix-4 FFT result interface.
- Snapshots the flattened stage-2 outputs (yr/yi, N×OUTW each) on a start pulse.
- Rescales each complex sample from Q15-accumulated OUTW to signed DOUTW with saturation.
- Streams the N samples one per handshake over a valid/ready port to downstream logic (DMA, UART framer, magnitude unit).

Parameters:
- N, 16, number of FFT points; fixed at 16 in this revision, index width 4.
- OUTW, 48, width of each signed sample in the flat input buses.
- DOUTW, 32, width of each signed streamed output sample.
- SHIFT, 15, arithmetic right-shift applied before saturation; removes Q15 twiddle scaling.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to snapshot the flat buses and begin streaming.
- yr_flat  input  N*OUTW  real parts; sample k occupies bits [k*OUTW +: OUTW], signed.
- yi_flat  input  N*OUTW  imaginary parts, same packing.
- busy  output  1  high from the accepted start until the final handshake completes.
- out_valid  output  1  current sample is presented.
- out_ready  input  1  downstream accepts the sample when high together with out_valid.
- out_idx  output  4  frequency index k of the presented sample.
- out_re  output  DOUTW  scaled, saturated real part.
- out_im  output  DOUTW  scaled, saturated imaginary part.
- out_last  output  1  high with out_valid when out_idx == N-1.
- sat_flag  output  1  sticky; set if any component saturated during the current frame.
- done  output  1  one-cycle pulse after the last handshake.

Behaviour:
- Reset: clk/rst synchronous, active-high. On reset, FSM goes to IDLE and all outputs go to 0 (busy, out_valid, out_idx, out_re, out_im, out_last, sat_flag, done). Snapshot contents are don't-care.
- States are IDLE, STREAM and FIN.
- IDLE:
  - start=1 registers all 2N samples into internal snapshot registers on that edge.
  - Sets busy=1, k=0, clears sat_flag, goes to STREAM.
  - start is ignored while busy=1.
- STREAM:
  - out_valid=1 from the cycle after start acceptance (latency 1).
  - out_re/out_im/out_idx/out_last are registered and reflect sample k.
  - Handshake occurs on an edge with out_valid & out_ready.
    - On a handshake with k<N-1: k increments and the next sample appears in the following cycle with no bubble.
    - On a handshake with k==N-1: go to FIN, out_valid=0.
  - While out_valid=1 and out_ready=0, every output holds stable.
  - With out_ready tied high, a frame takes exactly N cycles of out_valid.
- FIN: done=1 and busy=0 for exactly one cycle, then IDLE. A start in the FIN cycle is not accepted; the earliest accepted start is the cycle after done.
- Scaling, per component:
  - t = sample >>> SHIFT (arithmetic shift, truncation toward −inf).
  - If t > 2^(DOUTW-1)-1, output max and set sat_flag.
  - If t < −2^(DOUTW-1), output min and set sat_flag.
  - Otherwise output t[DOUTW-1:0].
- sat_flag stays set until the next accepted start or rst.
- Snapshot isolation: yr_flat/yi_flat changes after start acceptance do not affect the frame in flight.
- Reset mid-frame: outputs are 0 in the cycle after rst, no done pulse, and a new start restarts from k=0.

Optional Feature:
- DIGIT_REVERSE_EN defined:
  - Sample presented at index k is read from snapshot slot rev(k) = {k[1:0],k[3:2]} (base-4 digit reversal).
  - out_idx still reports k.
  - This converts radix-4 digit-reversed stage-2 order to natural frequency order.
- Undefined: slot k is presented at index k (natural pass-through). No other behaviour differs.

Test Plan:
- Natural stream, out_ready=1:
  - Stimulus: slot k real = k<<15, imag = −(k<<15); start at cycle 0.
  - Response: out_valid in cycles 1..16; out_re=k, out_im=−k, out_idx=k; out_last only at k=15; done at cycle 17; sat_flag=0.
- Backpressure:
  - Stimulus: same data, out_ready=0 for 3 cycles while k=5.
  - Response: out_idx=5, out_re=5, out_im=−5 held for 4 cycles; stream resumes at k=6; done delayed by 3 cycles.
- Saturation:
  - Stimulus: slot 3 real = 2^46, slot 4 imag = −2^47, others 0.
  - Response: out_re at k=3 is 2147483647; out_im at k=4 is −2147483648; sat_flag=1 until the next start, which clears it.
- Snapshot and ignore:
  - Stimulus: change yr_flat to all 1<<15 and pulse start at k=2.
  - Response: frame continues with original values; second start has no effect; busy stays high.
- Reset mid-frame:
  - Stimulus: rst=1 for one cycle at k=7.
  - Response: all outputs 0 next cycle, no done; a following start streams from k=0.
- DIGIT_REVERSE_EN build:
  - Stimulus: slot j real = j<<15.
  - Response: out_re at k=1,2,5,6 equals 4, 8, 5, 9 respectively.
